video_stream_monitor: RTL and testbench

Synthesizable, parametrised AXI4-Stream video protocol monitor and sink-side ready generator. It is the hardware successor to the simulation-only SOF/EOL checker and attaches to the `pixel_generator` output stream in test and bring-up builds. It drives `tready` in one of four run-time-selectable modes and tracks word, line and frame position. It flags SOF/EOL/timeout violations through sticky flags and a saturating error counter, so checking runs on silicon as well as in simulation.

---
 rtl/video_stream_monitor.sv | 187 ++++++++++++++++++
 tb/tb_video_stream_monitor.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_monitor.sv
// AXI4-Stream video sink monitor: drives tready in one of four modes, tracks
// word/line/frame position and records SOF/EOL/timeout violations.
module video_stream_monitor #(
    parameter int          X_SIZE   = 720,
    parameter int          Y_SIZE   = 720,
    parameter int          TIMEOUT  = 1000,
    parameter logic [32:0] RND_SEED = 33'h04A4C_2B4A,
    parameter int          ERR_W    = 16
) (
    input  logic                      out_stream_aclk,
    input  logic                      axi_resetn,
    input  logic                      tvalid,
    input  logic                      tuser,
    input  logic                      tlast,
    output logic                      tready,
    input  logic [1:0]                ready_mode,
    input  logic                      clr_err,
    output logic [$clog2(X_SIZE)-1:0] x_cnt,
    output logic [$clog2(Y_SIZE)-1:0] y_cnt,
    output logic [15:0]               frame_cnt,
    output logic                      frame_done,
    output logic                      locked,
    output logic [4:0]                err_flags,
    output logic [ERR_W-1:0]          err_count
);

    localparam int XW = $clog2(X_SIZE);
    localparam int YW = $clog2(Y_SIZE);
    localparam int TW = $clog2(TIMEOUT);
    localparam int CW = ERR_W + 2;

    localparam logic [0:0] S_HUNT   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    localparam logic [XW-1:0]    X_LAST  = XW'(X_SIZE - 1);
    localparam logic [YW-1:0]    Y_LAST  = YW'(Y_SIZE - 1);
    localparam logic [TW-1:0]    TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [0:0]       state_q, state_d;
    logic [32:0]      prbs_q, prbs_d;
    logic             tready_q, tready_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [15:0]      frame_q, frame_d;
    logic             fdone_q, fdone_d;
    logic [4:0]       flags_q, flags_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]    to_q, to_d;

    logic             beat;
    logic             at_origin;
    logic             take;
    logic [XW-1:0]    cur_x;
    logic [YW-1:0]    cur_y;
    logic             to_err;
    logic             sof_miss, sof_unexp, eol_miss, eol_unexp;
    logic [4:0]       new_err;
    logic [CW-1:0]    inc;
    logic [CW-1:0]    sum;

    assign beat      = tvalid & tready_q;
    assign at_origin = (x_q == '0) && (y_q == '0);

    always_comb begin
        prbs_d = {prbs_q[31:0], prbs_q[32] ^ ~prbs_q[19]};
        case (ready_mode)
            2'd0:    tready_d = 1'b1;
            2'd1:    tready_d = prbs_q[32];
            2'd2:    tready_d = tvalid & ~beat;
            default: tready_d = 1'b0;
        endcase
    end

    // Idle watchdog: one error per TIMEOUT consecutive cycles without tvalid.
    always_comb begin
        to_err = 1'b0;
        if (tvalid) begin
            to_d = '0;
        end else if (to_q == TO_LAST) begin
            to_err = 1'b1;
            to_d   = '0;
        end else begin
            to_d = to_q + TW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        frame_d   = frame_q;
        fdone_d   = 1'b0;
        sof_miss  = 1'b0;
        sof_unexp = 1'b0;
        eol_miss  = 1'b0;
        eol_unexp = 1'b0;
        take      = 1'b0;
        cur_x     = x_q;
        cur_y     = y_q;
        if (beat) begin
            if (state_q == S_HUNT) begin
                if (tuser) begin
                    take    = 1'b1;
                    state_d = S_ACTIVE;
                    cur_x   = '0;
                    cur_y   = '0;
                end
            end else begin
                take = 1'b1;
                if (tuser && !at_origin) begin
                    sof_unexp = 1'b1;
                    cur_x     = '0;
                    cur_y     = '0;
                end else if (!tuser && at_origin) begin
                    sof_miss = 1'b1;
                end
            end
        end
        // An early EOL on the last line wraps y without counting a frame.
        if (take) begin
            if (cur_x == X_LAST) begin
                eol_miss = ~tlast;
                x_d      = '0;
                if (cur_y == Y_LAST) begin
                    y_d     = '0;
                    frame_d = frame_q + 16'd1;
                    fdone_d = 1'b1;
                end else begin
                    y_d = cur_y + YW'(1);
                end
            end else if (tlast) begin
                eol_unexp = 1'b1;
                x_d       = '0;
                y_d       = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
            end else begin
                x_d = cur_x + XW'(1);
                y_d = cur_y;
            end
        end
    end

    always_comb begin
        new_err = {to_err, eol_unexp, eol_miss, sof_unexp, sof_miss};
        inc     = CW'(new_err[0]) + CW'(new_err[1]) + CW'(new_err[2])
                + CW'(new_err[3]) + CW'(new_err[4]);
        sum     = (clr_err ? '0 : CW'(cnt_q)) + inc;
        cnt_d   = (sum > CW'(ERR_MAX)) ? ERR_MAX : sum[ERR_W-1:0];
        flags_d = (clr_err ? 5'b0 : flags_q) | new_err;
    end

    always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q  <= S_HUNT;
            prbs_q   <= RND_SEED;
            tready_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            frame_q  <= '0;
            fdone_q  <= 1'b0;
            flags_q  <= '0;
            cnt_q    <= '0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            prbs_q   <= prbs_d;
            tready_q <= tready_d;
            x_q      <= x_d;
            y_q      <= y_d;
            frame_q  <= frame_d;
            fdone_q  <= fdone_d;
            flags_q  <= flags_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
        end
    end

    assign tready     = tready_q;
    assign x_cnt      = x_q;
    assign y_cnt      = y_q;
    assign frame_cnt  = frame_q;
    assign frame_done = fdone_q;
    assign locked     = (state_q == S_ACTIVE);
    assign err_flags  = flags_q;
    assign err_count  = cnt_q;

endmodule

// File: tb/tb_video_stream_monitor.sv
// Bench for video_stream_monitor: stimulus tasks push the reference model's
// expected outputs into a queue that a per-cycle monitor pops and compares.
module tb_video_stream_monitor;

    localparam int          X    = 4;
    localparam int          Y    = 3;
    localparam int          TO   = 10;
    localparam int          EW   = 5;
    localparam int          CMAX = (1 << EW) - 1;
    localparam logic [32:0] SEED = 33'h04A4C_2B4A;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0, clr_err = 1'b0;
    logic [1:0]    ready_mode = 2'd0;
    logic          tready, frame_done, locked;
    logic [1:0]    x_cnt, y_cnt;
    logic [15:0]   frame_cnt;
    logic [4:0]    err_flags;
    logic [EW-1:0] err_count;

    video_stream_monitor #(
        .X_SIZE(X), .Y_SIZE(Y), .TIMEOUT(TO), .RND_SEED(SEED), .ERR_W(EW)
    ) dut (
        .out_stream_aclk(clk), .axi_resetn(rst_n), .tvalid(tvalid), .tuser(tuser),
        .tlast(tlast), .tready(tready), .ready_mode(ready_mode), .clr_err(clr_err),
        .x_cnt(x_cnt), .y_cnt(y_cnt), .frame_cnt(frame_cnt), .frame_done(frame_done),
        .locked(locked), .err_flags(err_flags), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rdy;
        int       x;
        int       y;
        int       frames;
        bit       fdone;
        bit       locked;
        bit [4:0] flags;
        int       cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   fd_seen = 0;

    // Reference model state (plain integers, positions as word/line numbers)
    bit        m_rdy, m_sync, m_fdone;
    int        m_x, m_y, m_frames, m_cnt, m_to;
    bit [4:0]  m_flags;
    bit [32:0] m_prbs;

    bit        rst_req = 1'b0;
    bit [1:0]  cur_mode = 2'd0;
    bit        m2_chk = 1'b0;
    bit        mon_b, prev_b;
    exp_t      me;
    int        gx = 0, gy = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_rdy = 0; m_sync = 0; m_fdone = 0;
        m_x = 0; m_y = 0; m_frames = 0; m_cnt = 0; m_to = 0;
        m_flags = '0; m_prbs = SEED;
    endtask

    task automatic model_step(input bit v, input bit u, input bit l, input bit c,
                              input bit [1:0] m);
        bit       beat, nr;
        bit [4:0] e;
        int       px, py, n;
        beat = v && m_rdy;
        case (m)
            2'd0:    nr = 1'b1;
            2'd1:    nr = m_prbs[32];
            2'd2:    nr = beat ? 1'b0 : v;
            default: nr = 1'b0;
        endcase
        m_prbs  = {m_prbs[31:0], m_prbs[32] ^ ~m_prbs[19]};
        e       = '0;
        m_fdone = 0;
        if (v) m_to = 0;
        else if (m_to == TO - 1) begin e[4] = 1; m_to = 0; end
        else m_to++;
        if (beat && (m_sync || u)) begin
            px = m_x; py = m_y;
            if (!m_sync) begin m_sync = 1; px = 0; py = 0; end
            else if (u && !(px == 0 && py == 0)) begin e[1] = 1; px = 0; py = 0; end
            else if (!u && px == 0 && py == 0) e[0] = 1;
            if (px == X - 1) begin
                if (!l) e[2] = 1;
                m_x = 0;
                if (py == Y - 1) begin
                    m_y = 0; m_frames = (m_frames + 1) % 65536; m_fdone = 1;
                end else m_y = py + 1;
            end else if (l) begin
                e[3] = 1; m_x = 0; m_y = (py + 1) % Y;
            end else begin
                m_x = px + 1; m_y = py;
            end
        end
        if (c) begin m_flags = '0; m_cnt = 0; end
        m_flags = m_flags | e;
        n       = $countones(e);
        m_cnt   = (m_cnt + n > CMAX) ? CMAX : m_cnt + n;
        m_rdy   = nr;
    endtask

    task automatic tick(input bit v, input bit u, input bit l, input bit c, output bit acc);
        exp_t e;
        @(negedge clk);
        rst_n = rst_req; tvalid = v; tuser = u; tlast = l; clr_err = c;
        ready_mode = cur_mode;
        acc = rst_req && v && m_rdy;
        if (!rst_req) model_reset();
        else model_step(v, u, l, c, cur_mode);
        e.rdy = m_rdy; e.x = m_x; e.y = m_y; e.frames = m_frames; e.fdone = m_fdone;
        e.locked = m_sync; e.flags = m_flags; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic idle(input int n, input bit c);
        bit acc;
        for (int i = 0; i < n; i++) tick(0, 0, 0, c, acc);
    endtask

    task automatic send(input bit u, input bit l, input bit c);
        bit acc;
        int n = 0;
        do begin
            tick(1, u, l, c, acc);
            n++;
        end while (!acc && n < 64);
    endtask

    task automatic rand_ticks(input int n, input bit with_clr);
        bit acc, v, u, l, c;
        for (int i = 0; i < n; i++) begin
            v = ($urandom % 8) != 0;
            u = (gx == 0 && gy == 0);
            if ($urandom % 30 == 0) u = ~u;
            l = (gx == X - 1);
            if ($urandom % 30 == 0) l = ~l;
            c = with_clr && ($urandom % 100 == 0);
            tick(v, u, l, c, acc);
            if (acc) begin
                if (l) begin gx = 0; gy = (gy + 1) % Y; end
                else gx = (gx + 1) % X;
            end
        end
    endtask

    always @(posedge clk) begin
        mon_b = tvalid && tready;
        #1;
        if (m2_chk && rst_n && mon_b) check("mode2_back_to_back", prev_b, 0);
        prev_b = mon_b;
        if (frame_done) fd_seen++;
        if (sb.size() > 0) begin
            me = sb.pop_front();
            check("tready", tready, me.rdy);
            check("x_cnt", x_cnt, me.x);
            check("y_cnt", y_cnt, me.y);
            check("frame_cnt", frame_cnt, me.frames);
            check("frame_done", frame_done, me.fdone);
            check("locked", locked, me.locked);
            check("err_flags", err_flags, me.flags);
            check("err_count", err_count, me.cnt);
        end
    end

    initial begin
        model_reset();
        rst_req = 0;
        idle(3, 0);
        rst_req = 1;

        // HUNT discards, then two clean frames in mode 0
        cur_mode = 2'd0;
        for (int i = 0; i < 3; i++) send(0, 0, 0);
        send(1, 0, 0);
        check("hunt_unlocked", locked, 0);
        for (int f = 0; f < 2; f++)
            for (int y = 0; y < Y; y++)
                for (int x = 0; x < X; x++) begin
                    if (f != 0 || y != 0 || x != 0) send(x == 0 && y == 0, x == X - 1, 0);
                    if (f == 0 && y == 0 && x == 1) check("locked_after_sof", locked, 1);
                end
        idle(1, 0);
        check("two_frames", frame_cnt, 2);
        check("two_done_pulses", fd_seen, 2);
        check("clean_flags", err_flags, 0);

        // Early EOL on line 0, then missing EOL on line 1
        send(1, 0, 0);
        send(0, 1, 0);
        idle(1, 0);
        check("err3_flags", err_flags, 5'b01000);
        check("err3_count", err_count, 1);
        check("err3_y", y_cnt, 1);
        check("err3_x", x_cnt, 0);
        for (int x = 0; x < X; x++) send(0, 0, 0);
        idle(1, 0);
        check("err2_flags", err_flags, 5'b01100);
        check("err2_count", err_count, 2);

        // Finish frame, then unexpected SOF mid-line
        for (int x = 0; x < X; x++) send(0, x == X - 1, 0);
        for (int x = 0; x < X; x++) send(x == 0, x == X - 1, 0);
        send(0, 0, 0);
        send(0, 0, 0);
        send(1, 0, 0);
        idle(1, 0);
        check("err1_flags", err_flags, 5'b01110);
        check("err1_frames", frame_cnt, 3);
        check("err1_resync_x", x_cnt, 1);
        check("err1_resync_y", y_cnt, 0);
        send(0, 1, 1);
        idle(1, 0);
        check("clr_vs_err_flags", err_flags, 5'b01000);
        check("clr_vs_err_count", err_count, 1);

        // Timeouts and saturation
        idle(1, 1);
        idle(24, 0);
        check("timeout_flags", err_flags, 5'b10000);
        check("timeout_count", err_count, 2);
        idle(TO * (CMAX + 6 - 2) + 5, 0);
        check("count_saturated", err_count, CMAX);

        // PRBS and after-valid ready modes
        cur_mode = 2'd1;
        idle(1, 1);
        rand_ticks(100, 0);
        cur_mode = 2'd2;
        m2_chk = 1;
        rand_ticks(80, 0);
        m2_chk = 0;

        // Reset in the middle of a line
        cur_mode = 2'd0;
        idle(1, 0);
        send(0, 0, 0);
        send(0, 0, 0);
        rst_req = 0;
        idle(1, 0);
        #1;
        check("rst_tready", tready, 0);
        check("rst_x", x_cnt, 0);
        check("rst_y", y_cnt, 0);
        check("rst_frames", frame_cnt, 0);
        check("rst_locked", locked, 0);
        check("rst_flags", err_flags, 0);
        check("rst_count", err_count, 0);
        idle(1, 0);
        rst_req = 1;
        send(0, 0, 0);
        send(0, 0, 0);
        check("rst_hunt", locked, 0);

        // Randomised mix of modes, errors and clears
        gx = 0; gy = 0;
        for (int k = 0; k < 30; k++) begin
            cur_mode = 2'($urandom_range(0, 3));
            if (cur_mode == 2'd3 && ($urandom % 2 == 0)) cur_mode = 2'd0;
            if ($urandom % 15 == 0) begin
                rst_req = 0;
                idle(2, 0);
                rst_req = 1;
            end
            rand_ticks(60, 1);
        end

        idle(2, 0);
        @(posedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
